// File: rtl/pulse_shaper_pkg.sv
// Shared constants for the pulse_shaper block: retrigger mode encodings.
package pulse_shaper_pkg;

  localparam int PULSE_SHAPER_MODE_W = 2;

  localparam logic [PULSE_SHAPER_MODE_W-1:0] PULSE_SHAPER_MODE_RESTART    = 2'd0;
  localparam logic [PULSE_SHAPER_MODE_W-1:0] PULSE_SHAPER_MODE_IGNORE     = 2'd1;
  localparam logic [PULSE_SHAPER_MODE_W-1:0] PULSE_SHAPER_MODE_ACCUMULATE = 2'd2;

endpackage

// File: rtl/pulse_shaper_channel.sv
// One pulse_shaper channel: trigger detect, down-counter, optional hold-off
// window (PULSE_SHAPER_HOLDOFF_EN) and registered start/dropped flags.
module pulse_shaper_channel
  import pulse_shaper_pkg::*;
#(
  parameter int LENGTH_WIDTH   = 8,
  parameter int EDGE_TRIGGER   = 0,
  parameter int HOLDOFF_LENGTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           trigger_in,
  input  logic [LENGTH_WIDTH-1:0]        length,
  input  logic [PULSE_SHAPER_MODE_W-1:0] mode,
  output logic                           pulse_out,
  output logic                           pulse_start,
  output logic                           trigger_dropped
);

  localparam logic [LENGTH_WIDTH-1:0] ONE = LENGTH_WIDTH'(1);

  if (HOLDOFF_LENGTH < 1 || LENGTH_WIDTH < 1) begin : g_param_check
    $error("pulse_shaper_channel: HOLDOFF_LENGTH and LENGTH_WIDTH must be >= 1");
  end

  logic [LENGTH_WIDTH-1:0] r_count;
  logic                    r_trigger_q;
  logic                    r_start;
  logic                    r_dropped;

  logic                    w_trig;
  logic                    w_active;
  logic                    w_in_holdoff;
  logic [LENGTH_WIDTH:0]   w_sum;
  logic [LENGTH_WIDTH-1:0] w_count_nxt;
  logic                    w_start_nxt;
  logic                    w_dropped_nxt;

  assign w_trig   = ((EDGE_TRIGGER != 0) ? (trigger_in & ~r_trigger_q) : trigger_in)
                    && (length != '0);
  assign w_active = (r_count != '0);
  // r_count >= 1 whenever this is used, so the decrement cannot wrap.
  assign w_sum    = ({1'b0, r_count} - {1'b0, ONE}) + {1'b0, length};

`ifdef PULSE_SHAPER_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_LENGTH + 1);
  logic [HW-1:0] r_holdoff;

  assign w_in_holdoff = (r_holdoff != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_holdoff <= '0;
    end else if (r_count == ONE && w_count_nxt == '0) begin
      r_holdoff <= HW'(HOLDOFF_LENGTH);
    end else if (w_in_holdoff) begin
      r_holdoff <= r_holdoff - HW'(1);
    end
  end
`else
  assign w_in_holdoff = 1'b0;
`endif

  always_comb begin
    w_count_nxt   = w_active ? (r_count - ONE) : r_count;
    w_start_nxt   = 1'b0;
    w_dropped_nxt = 1'b0;
    if (w_trig) begin
      if (!w_active) begin
        if (w_in_holdoff) begin
          w_dropped_nxt = 1'b1;
        end else begin
          w_count_nxt = length;
          w_start_nxt = 1'b1;
        end
      end else begin
        case (mode)
          PULSE_SHAPER_MODE_IGNORE:     w_dropped_nxt = 1'b1;
          PULSE_SHAPER_MODE_ACCUMULATE: w_count_nxt = w_sum[LENGTH_WIDTH] ? '1
                                                      : w_sum[LENGTH_WIDTH-1:0];
          default:                      w_count_nxt = length;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_trigger_q <= 1'b0;
      r_start     <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_trigger_q <= trigger_in;
      r_start     <= w_start_nxt;
      r_dropped   <= w_dropped_nxt;
    end
  end

  assign pulse_out       = w_active;
  assign pulse_start     = r_start;
  assign trigger_dropped = r_dropped;

endmodule

// File: rtl/pulse_shaper.sv
// Multi-channel programmable pulse stretcher. Optional hold-off window is
// enabled by defining PULSE_SHAPER_HOLDOFF_EN.
module pulse_shaper
  import pulse_shaper_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int LENGTH_WIDTH   = 8,
  parameter int EDGE_TRIGGER   = 0,
  parameter int HOLDOFF_LENGTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            trigger_in,
  input  logic [LENGTH_WIDTH-1:0]        length,
  input  logic [PULSE_SHAPER_MODE_W-1:0] mode,
  output logic [CHANNELS-1:0]            pulse_out,
  output logic [CHANNELS-1:0]            pulse_start,
  output logic [CHANNELS-1:0]            trigger_dropped,
  output logic                           busy
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pulse_shaper_channel #(
      .LENGTH_WIDTH  (LENGTH_WIDTH),
      .EDGE_TRIGGER  (EDGE_TRIGGER),
      .HOLDOFF_LENGTH(HOLDOFF_LENGTH)
    ) u_channel (
      .clock          (clock),
      .reset          (reset),
      .trigger_in     (trigger_in[g]),
      .length         (length),
      .mode           (mode),
      .pulse_out      (pulse_out[g]),
      .pulse_start    (pulse_start[g]),
      .trigger_dropped(trigger_dropped[g])
    );
  end

  assign busy = |pulse_out;

endmodule
